// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide issue path:
// the MD op encodings, default unit latencies and the issue FSM state type.
package md_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'h0,
    MD_MULTU = 4'h1,
    MD_DIV   = 4'h2,
    MD_DIVU  = 4'h3,
    MD_MTHI  = 4'h4,
    MD_MTLO  = 4'h5,
    MD_MFHI  = 4'h6,
    MD_MFLO  = 4'h7,
    MD_NONE  = 4'hF
  } md_op_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W_DEF   = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Codes 0..3 are the operations that keep the unit busy.
  function automatic logic is_arith(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

  function automatic logic is_hilo_write(input logic [3:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline-side signal bundle of the MD issue controller.
// master = pipeline / MD unit side, slave = the controller itself.
interface md_issue_ctrl_if;
  logic        e_valid;
  logic        e_hold;
  logic [3:0]  e_md_op;
  logic        int_req;
  logic        d_md_use;
  logic        md_busy;
  logic        md_start;
  logic [3:0]  md_ctrl;
  logic        stall_d;
  logic [31:0] issue_cnt;
  logic        sync_err;

  modport master (
    output e_valid, e_hold, e_md_op, int_req, d_md_use, md_busy,
    input  md_start, md_ctrl, stall_d, issue_cnt, sync_err
  );

  modport slave (
    input  e_valid, e_hold, e_md_op, int_req, d_md_use, md_busy,
    output md_start, md_ctrl, stall_d, issue_cnt, sync_err
  );
endinterface

// File: rtl/md_lat_counter.sv
// Shadow latency counter: loads a latency, counts down to zero, flags zero.
module md_lat_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage MD issue controller: start pulse + op code, shadow busy counter
// for early D-stage stalling, busy cross-check and issued-op counter.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  md_issue_ctrl_if.slave bus
);

  md_state_e        state_reg, state_next;
  logic             issued_reg, issued_next;
  logic [31:0]      issue_cnt_reg;
  logic             sync_err_reg;
  logic             pass_op, fire;
  logic             load, dec;
  logic [CNT_W-1:0] load_val, cnt;
  logic             cnt_zero;

  md_lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // An E instruction forwards its op only once; held repeats see MD_NONE.
  always_comb begin
    pass_op      = bus.e_valid && !issued_reg && !bus.int_req;
    fire         = pass_op && is_arith(bus.e_md_op);
    bus.md_start = fire;
    bus.md_ctrl  = pass_op ? bus.e_md_op : MD_NONE;
    bus.stall_d  = bus.d_md_use && (fire || !cnt_zero);
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    dec        = 1'b0;
    load_val   = bus.e_md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    case (state_reg)
      ST_IDLE: begin
        if (fire) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fire) begin
          load = 1'b1;
        end else begin
          dec = 1'b1;
          if (cnt == CNT_W'(1)) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    issued_next = issued_reg;
    if (!bus.e_hold || bus.int_req) begin
      issued_next = 1'b0;
    end else if (pass_op && (is_arith(bus.e_md_op) || is_hilo_write(bus.e_md_op))) begin
      issued_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      issued_reg    <= 1'b0;
      issue_cnt_reg <= '0;
      sync_err_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      issued_reg <= issued_next;
      if (fire) issue_cnt_reg <= issue_cnt_reg + 32'd1;
      // A fire while running means the stall logic was bypassed somewhere.
      if ((!cnt_zero != bus.md_busy) || (fire && (state_reg == ST_RUN)))
        sync_err_reg <= 1'b1;
    end
  end

  assign bus.issue_cnt = issue_cnt_reg;
  assign bus.sync_err  = sync_err_reg;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios plus randomized pipeline traffic,
// checked each cycle against a remaining-latency model of the issue rules.
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_issue_ctrl_if bus();

  md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // MD unit stand-in: busy for LAT cycles after a start, optionally dropping early.
  int   u_rem = 0;
  logic drop_early = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) u_rem <= 0;
    else if (bus.md_start) u_rem <= bus.md_ctrl[1] ? DIV_LAT : MUL_LAT;
    else if (u_rem > 0) u_rem <= u_rem - 1;
  end
  assign bus.md_busy = (u_rem != 0) && !(drop_early && (u_rem == 1));

  // Reference model: cycles of unit work remaining, issued flag, counters.
  int          m_rem = 0;
  bit          m_issued = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_cnt = '0;

  function automatic bit exp_pass();
    return bus.e_valid && !m_issued && !bus.int_req;
  endfunction

  function automatic bit exp_fire();
    return exp_pass() && (bus.e_md_op <= 4'd3);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem    <= 0;
      m_issued <= 1'b0;
      m_err    <= 1'b0;
      m_cnt    <= '0;
    end else begin
      if (exp_fire()) begin
        m_rem <= (bus.e_md_op >= 4'd2) ? DIV_LAT : MUL_LAT;
        m_cnt <= m_cnt + 32'd1;
        if (m_rem != 0) m_err <= 1'b1;
        $display("issue op=%0d total=%0d t=%0t", bus.e_md_op, m_cnt + 32'd1, $time);
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
      end
      if ((m_rem != 0) != bus.md_busy) m_err <= 1'b1;
      m_issued <= bus.e_hold && !bus.int_req &&
                  (m_issued || (exp_pass() && (bus.e_md_op <= 4'd5)));
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("md_start", bus.md_start, exp_fire());
      chk("md_ctrl", bus.md_ctrl, exp_pass() ? bus.e_md_op : 4'hF);
      chk("stall_d", bus.stall_d, bus.d_md_use && (exp_fire() || (m_rem != 0)));
      chk("issue_cnt", bus.issue_cnt, m_cnt);
      chk("sync_err", bus.sync_err, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic hold, input logic [3:0] op,
                       input logic irq, input logic duse);
    bus.e_valid  = v;
    bus.e_hold   = hold;
    bus.e_md_op  = op;
    bus.int_req  = irq;
    bus.d_md_use = duse;
    #1;
  endtask

  task automatic idle(input int n, input logic duse);
    for (int i = 0; i < n; i++) begin
      step();
      drive(1'b0, 1'b0, MD_NONE, 1'b0, duse);
    end
  endtask

  initial begin
    logic       prev_hold;
    logic       prev_irq;
    logic       v;
    logic [3:0] op;

    bus.e_valid = 1'b0; bus.e_hold = 1'b0; bus.e_md_op = MD_NONE;
    bus.int_req = 1'b0; bus.d_md_use = 1'b1;
    #1 reset = 1'b1;
    #2;
    chk("rst_start", bus.md_start, 1'b0);
    chk("rst_ctrl", bus.md_ctrl, 4'hF);
    chk("rst_stall", bus.stall_d, 1'b0);
    chk("rst_issue_cnt", bus.issue_cnt, 32'd0);
    chk("rst_sync_err", bus.sync_err, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // MULT, not held: one start, busy window t1..t5
    step(); drive(1'b1, 1'b0, MD_MULT, 1'b0, 1'b1);
    chk("t1_start", bus.md_start, 1'b1);
    chk("t1_stall_t0", bus.stall_d, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(); drive(1'b0, 1'b0, MD_NONE, 1'b0, 1'b1);
      chk("t1_stall_win", bus.stall_d, (k <= 5) ? 1'b1 : 1'b0);
      chk("t1_start_once", bus.md_start, 1'b0);
    end
    chk("t1_issue_cnt", bus.issue_cnt, 32'd1);
    chk("t1_sync_err", bus.sync_err, 1'b0);
    $display("T1 MULT issue_cnt=%0d", bus.issue_cnt);

    // DIV with D-stage MD user: stall t0..t10, MFLO enters at t11
    step(); drive(1'b1, 1'b0, MD_DIV, 1'b0, 1'b1);
    chk("t2_stall_t0", bus.stall_d, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step(); drive(1'b0, 1'b0, MD_NONE, 1'b0, 1'b1);
      chk("t2_stall_win", bus.stall_d, 1'b1);
    end
    step(); drive(1'b1, 1'b0, MD_MFLO, 1'b0, 1'b1);
    chk("t2_stall_t11", bus.stall_d, 1'b0);
    chk("t2_ctrl_mflo", bus.md_ctrl, 4'd7);
    idle(1, 1'b1);
    chk("t2_stall_t12", bus.stall_d, 1'b0);
    chk("t2_issue_cnt", bus.issue_cnt, 32'd2);
    $display("T2 DIV issue_cnt=%0d", bus.issue_cnt);

    // MULTU held in E for three cycles
    step(); drive(1'b1, 1'b1, MD_MULTU, 1'b0, 1'b0);
    chk("t3_start_c1", bus.md_start, 1'b1);
    chk("t3_ctrl_c1", bus.md_ctrl, 4'd1);
    step(); drive(1'b1, 1'b1, MD_MULTU, 1'b0, 1'b0);
    chk("t3_start_c2", bus.md_start, 1'b0);
    chk("t3_ctrl_c2", bus.md_ctrl, 4'hF);
    step(); drive(1'b1, 1'b0, MD_MULTU, 1'b0, 1'b0);
    chk("t3_start_c3", bus.md_start, 1'b0);
    chk("t3_ctrl_c3", bus.md_ctrl, 4'hF);
    idle(6, 1'b0);
    chk("t3_issue_cnt", bus.issue_cnt, 32'd3);
    $display("T3 MULTU held issue_cnt=%0d", bus.issue_cnt);

    // DIVU cancelled by int_req, then int_req during a running MULT
    step(); drive(1'b1, 1'b0, MD_DIVU, 1'b1, 1'b1);
    chk("t4_start_irq", bus.md_start, 1'b0);
    chk("t4_ctrl_irq", bus.md_ctrl, 4'hF);
    chk("t4_stall_irq", bus.stall_d, 1'b0);
    idle(1, 1'b1);
    chk("t4_no_count", bus.stall_d, 1'b0);
    step(); drive(1'b1, 1'b0, MD_MULT, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(); drive(1'b0, 1'b0, MD_NONE, (k == 2) ? 1'b1 : 1'b0, 1'b1);
      chk("t4_irq_run", bus.stall_d, (k <= 5) ? 1'b1 : 1'b0);
    end
    chk("t4_issue_cnt", bus.issue_cnt, 32'd4);
    $display("T4 int_req issue_cnt=%0d", bus.issue_cnt);

    // Unit drops busy early -> sticky sync_err; async reset mid-RUN
    drop_early = 1'b1;
    step(); drive(1'b1, 1'b0, MD_MULT, 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("t5_sync_err", bus.sync_err, 1'b1);
    idle(5, 1'b0);
    chk("t5_sync_sticky", bus.sync_err, 1'b1);
    step(); drive(1'b1, 1'b0, MD_MULT, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("t5_stall_pre", bus.stall_d, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_stall", bus.stall_d, 1'b0);
    chk("t5_rst_sync_err", bus.sync_err, 1'b0);
    chk("t5_rst_issue_cnt", bus.issue_cnt, 32'd0);
    @(posedge clk); #1 reset = 1'b0; drop_early = 1'b0;
    $display("T5 sync_err/reset done");

    // MTHI, MTLO, MFHI back to back
    step(); drive(1'b1, 1'b0, MD_MTHI, 1'b0, 1'b1);
    chk("t6_ctrl_mthi", bus.md_ctrl, 4'd4);
    chk("t6_stall", bus.stall_d, 1'b0);
    step(); drive(1'b1, 1'b0, MD_MTLO, 1'b0, 1'b1);
    chk("t6_ctrl_mtlo", bus.md_ctrl, 4'd5);
    chk("t6_start", bus.md_start, 1'b0);
    step(); drive(1'b1, 1'b0, MD_MFHI, 1'b0, 1'b1);
    chk("t6_ctrl_mfhi", bus.md_ctrl, 4'd6);
    chk("t6_stall_mf", bus.stall_d, 1'b0);
    idle(1, 1'b0);
    $display("T6 HI/LO moves done");

    // Randomized traffic; arithmetic ops only reach E while the unit is idle
    prev_hold = 1'b0;
    prev_irq  = 1'b0;
    v  = 1'b0;
    op = MD_NONE;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!prev_hold || prev_irq) begin
        v = ($urandom_range(0, 3) != 0);
        op = 4'($urandom_range(0, 9));
        if (op > 4'd7) op = MD_NONE;
        if ((op <= 4'd3) && (m_rem != 0)) op = 4'(4 + $urandom_range(0, 3));
      end
      prev_hold = ($urandom_range(0, 3) == 0);
      prev_irq  = ($urandom_range(0, 15) == 0);
      drive(v, prev_hold, op, prev_irq, 1'($urandom_range(0, 1)));
    end
    idle(12, 1'b0);
    chk("rand_sync_err", bus.sync_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
E-stage issue controller that sits directly upstream of the E-stage multiply/divide unit (HI/LO unit).
- Turns the decoded E-stage MD operation into a single-cycle start pulse plus an operation code.
- Keeps a shadow latency counter so D-stage MD instructions can be stalled in the same cycle an operation is issued, one cycle before the unit's own busy output rises.
- Cross-checks the shadow counter against the unit's busy output and counts issued operations.

Parameters:
MUL_LAT, 5, busy cycles after a MULT/MULTU start
DIV_LAT, 10, busy cycles after a DIV/DIVU start
CNT_W, 5, shadow counter width; must hold max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
e_valid  in  1  E stage holds a real instruction
e_hold  in  1  E stage frozen this cycle (instruction stays in E)
e_md_op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO, F none
int_req  in  1  interrupt/exception taken this cycle; E instruction is cancelled
d_md_use  in  1  D-stage instruction is any MD op (codes 0-7)
md_busy  in  1  busy output of the MD unit
md_start  out  1  start pulse to the MD unit
md_ctrl  out  4  operation code to the MD unit
stall_d  out  1  freeze D (and the stages before it)
issue_cnt  out  32  number of MULT/MULTU/DIV/DIVU operations issued
sync_err  out  1  sticky: shadow counter disagreed with md_busy

Behaviour:
- Reset (asynchronous, active-high): state IDLE, cnt=0, issued=0, issue_cnt=0, sync_err=0. Combinational outputs follow from these values, so md_start=0, md_ctrl=F, stall_d=0.
- is_arith = e_op in 0..3.
- fire = e_valid & is_arith & !issued & !int_req.
  - md_start = fire. This is combinational, in the same cycle.
- md_ctrl:
  - = e_md_op when e_valid & !issued & !int_req;
  - = 4'hF otherwise. This prevents repeat MTHI/MTLO writes while E is held.
- issued flag (one issue per E instruction):
  - set when fire & e_hold;
  - cleared when !e_hold or int_req.
  - An arithmetic op held in E therefore pulses start exactly once.
  - MTHI/MTLO also set issued while held.
- FSM, states IDLE and RUN:
  - IDLE: on fire, load cnt = LAT (MUL_LAT for codes 0/1, DIV_LAT for 2/3) and go to RUN.
  - RUN: cnt decrements every cycle. When cnt==1, next state is IDLE and cnt becomes 0.
  - fire cannot occur in RUN, because stall_d keeps MD ops out of E. If fire does occur in RUN, cnt is reloaded and sync_err is set.
  - int_req during RUN does not cancel: the unit finishes the operation, so counting continues.
- Timing: start in cycle t means RUN (cnt!=0) in cycles t+1 .. t+LAT. This matches md_busy exactly.
- stall_d = d_md_use & (fire | cnt!=0).
  - The issue cycle is covered even though md_busy is still 0.
  - MFHI/MFLO behind a pending op are stalled until the result is written.
- issue_cnt increments by 1 on every fire and wraps at 2^32.
- sync_err is set on any cycle where (cnt!=0) != md_busy. It is cleared only by reset.
- Reset mid-RUN: state and cnt return to 0 immediately, asynchronously.

Decomposition:
- Shared package holds:
  - the MD op encodings (0-7 plus F none), shared with the MD unit and the decoder;
  - MUL_LAT/DIV_LAT defaults;
  - the FSM state type (IDLE, RUN).
- One natural sub-module: md_lat_counter (load/decrement/zero-flag counter, CNT_W bits), instantiated once.

Test Plan:
- MULT, e_valid=1, e_hold=0 at t0 -> md_start=1 only at t0; cnt 5..1 over t1..t5 with md_busy mirrored; issue_cnt=1; sync_err stays 0.
- DIV at t0 with d_md_use=1 on t0..t12 -> stall_d=1 on t0..t10, 0 at t11; MFLO from D enters E at t11.
- MULTU held in E (e_hold=1) for 3 cycles -> exactly one md_start; md_ctrl=1 in the first cycle, F in the second and third; issue_cnt=1.
- DIVU with int_req=1 in the same cycle -> md_start=0, md_ctrl=F, cnt stays 0; int_req at t2 of a running MULT -> cnt keeps counting to 0 at t6.
- Unit model forced to drop md_busy one cycle early -> sync_err=1 and stays 1 until reset; assert reset mid-RUN (cnt=3) -> cnt=0 and stall_d=0 immediately, without waiting for a clock edge.
- MTHI, MTLO, then MFHI back-to-back, no arithmetic op -> md_start never 1, stall_d=0 throughout, md_ctrl = 4, 5, 6 in successive cycles.
